// File: rtl/exec_sequencer.sv
// Multi-cycle execute stage driving the read and write ports of an 8x16
// register file: load A, load B, shift and execute, then write back.
module exec_sequencer #(
   parameter int W  = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    op,
   input  logic [1:0]    shift,
   input  logic [RW-1:0] rn,
   input  logic [RW-1:0] rm,
   input  logic [RW-1:0] rd,
   input  logic          bsel,
   input  logic [W-1:0]  imm,
   input  logic          wb_en,
   input  logic [W-1:0]  rf_rdata,
   output logic [RW-1:0] rf_readnum,
   output logic [RW-1:0] rf_writenum,
   output logic          rf_write,
   output logic [W-1:0]  rf_wdata,
   output logic          done,
   output logic          z_flag,
   output logic          n_flag,
   output logic          v_flag
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_EXEC,
      S_WRITE
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, imm_q, imm_d;
   logic [1:0]    op_q, op_d, shift_q, shift_d;
   logic [RW-1:0] rm_q, rm_d, rd_q, rd_d, readnum_q, readnum_d;
   logic          bsel_q, bsel_d, wb_en_q, wb_en_d;
   logic          z_q, z_d, n_q, n_d, v_q, v_d;

   logic [W-1:0]  bs;
   logic [W-1:0]  alu_res;
   logic          alu_v;

   // Shifter on B followed by the ALU; V only meaningful for ADD/SUB.
   always_comb begin
      unique case (shift_q)
         2'b01:   bs = {b_q[W-2:0], 1'b0};
         2'b10:   bs = {1'b0, b_q[W-1:1]};
         2'b11:   bs = {b_q[W-1], b_q[W-1:1]};
         default: bs = b_q;
      endcase
      alu_v = 1'b0;
      unique case (op_q)
         OP_ADD: begin
            alu_res = a_q + bs;
            alu_v   = (a_q[W-1] == bs[W-1]) && (alu_res[W-1] != a_q[W-1]);
         end
         OP_SUB: begin
            alu_res = a_q - bs;
            alu_v   = (a_q[W-1] != bs[W-1]) && (alu_res[W-1] != a_q[W-1]);
         end
         OP_AND:  alu_res = a_q & bs;
         default: alu_res = ~bs;
      endcase
   end

   // Next-state and datapath register updates for each sequencer state.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves one
      // unassigned, which would infer a latch.
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      imm_d     = imm_q;
      op_d      = op_q;
      shift_d   = shift_q;
      rm_d      = rm_q;
      rd_d      = rd_q;
      readnum_d = readnum_q;
      bsel_d    = bsel_q;
      wb_en_d   = wb_en_q;
      z_d       = z_q;
      n_d       = n_q;
      v_d       = v_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d      = op;
               shift_d   = shift;
               rm_d      = rm;
               rd_d      = rd;
               bsel_d    = bsel;
               imm_d     = imm;
               wb_en_d   = wb_en;
               readnum_d = rn;
               state_d   = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            a_d       = rf_rdata;
            readnum_d = rm_q;
            state_d   = S_LOAD_B;
         end
         S_LOAD_B: begin
            b_d     = bsel_q ? imm_q : rf_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            c_d     = alu_res;
            z_d     = (alu_res == '0);
            n_d     = alu_res[W-1];
            v_d     = alu_v;
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any command in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         imm_q     <= '0;
         op_q      <= '0;
         shift_q   <= '0;
         rm_q      <= '0;
         rd_q      <= '0;
         readnum_q <= '0;
         bsel_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
         v_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
         imm_q     <= imm_d;
         op_q      <= op_d;
         shift_q   <= shift_d;
         rm_q      <= rm_d;
         rd_q      <= rd_d;
         readnum_q <= readnum_d;
         bsel_q    <= bsel_d;
         wb_en_q   <= wb_en_d;
         z_q       <= z_d;
         n_q       <= n_d;
         v_q       <= v_d;
      end
   end

   // Outputs decode from registered state only; ready is also masked by reset.
   assign cmd_ready   = (state_q == S_IDLE) && !reset;
   assign done        = (state_q == S_WRITE);
   assign rf_write    = (state_q == S_WRITE) && wb_en_q;
   assign rf_writenum = rd_q;
   assign rf_wdata    = c_q;
   assign rf_readnum  = readnum_q;
   assign z_flag      = z_q;
   assign n_flag      = n_q;
   assign v_flag      = v_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer with a behavioural 8x16 register file.
module tb_exec_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  op, shift;
   logic [2:0]  rn, rm, rd;
   logic        bsel;
   logic [15:0] imm;
   logic        wb_en;
   logic [15:0] rf_rdata;
   logic [2:0]  rf_readnum, rf_writenum;
   logic        rf_write;
   logic [15:0] rf_wdata;
   logic        done, z_flag, n_flag, v_flag;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   exec_sequencer #(.W(16), .RW(3)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .op(op), .shift(shift), .rn(rn), .rm(rm), .rd(rd), .bsel(bsel),
      .imm(imm), .wb_en(wb_en), .rf_rdata(rf_rdata), .rf_readnum(rf_readnum),
      .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_wdata(rf_wdata),
      .done(done), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag)
   );

   // Register file model: combinational read, write on rising edge.
   logic [15:0] rf [8];
   logic        pre_we = 1'b0;
   logic [2:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;

   assign rf_rdata = rf[rf_readnum];

   always @(posedge clk) begin
      if (rf_write) rf[rf_writenum] <= rf_wdata;
      else if (pre_we) rf[pre_addr] <= pre_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [2:0] addr, input logic [15:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = addr; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic set_cmd(input logic [1:0] o, input logic [1:0] s, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] d, input logic bs,
                          input logic [15:0] im, input logic wb);
      op = o; shift = s; rn = a; rm = b; rd = d; bsel = bs; imm = im; wb_en = wb;
   endtask

   // Issue one command from IDLE and watch the four busy cycles.
   task automatic run_cmd(input string name, input logic exp_wb);
      int done_cnt, done_k, wr_cnt, wr_k, ready_hi;
      done_cnt = 0; done_k = -1; wr_cnt = 0; wr_k = -1; ready_hi = 0;
      @(negedge clk);
      check({name, " ready_before"}, cmd_ready, 1);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (done)      begin done_cnt++; done_k = k; end
         if (rf_write)  begin wr_cnt++;   wr_k = k;   end
         if (cmd_ready) ready_hi++;
         @(negedge clk);
      end
      check({name, " done_count"}, done_cnt, 1);
      check({name, " done_cycle"}, done_k, 3);
      check({name, " write_count"}, wr_cnt, {31'd0, exp_wb});
      if (exp_wb) check({name, " write_cycle"}, wr_k, 3);
      check({name, " ready_busy"}, ready_hi, 0);
      check({name, " ready_after"}, cmd_ready, 1);
   endtask

   typedef struct {
      string       name;
      logic [1:0]  op, shift;
      logic [2:0]  rn, rm, rd;
      logic        bsel;
      logic [15:0] imm;
      logic        wb;
      logic [15:0] a_val, b_val, exp_c;
      logic [2:0]  exp_znv;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [15:0] exp_rd;
      int accepts, busy, dones, last_acc;

      vecs[0] = '{"add_basic",  2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0003, 16'h0008, 3'b000};
      vecs[1] = '{"sub_cmp",    2'd1, 2'd0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b0, 16'h0005, 16'h0005, 16'h0000, 3'b100};
      vecs[2] = '{"add_ovf",    2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0001, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 3'b011};
      vecs[3] = '{"sub_ovf",    2'd1, 2'd0, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0001, 1'b1, 16'h8000, 16'h0000, 16'h7FFF, 3'b001};
      vecs[4] = '{"add_asr",    2'd0, 2'd3, 3'd0, 3'd4, 3'd6, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h8004, 16'hC002, 3'b010};
      vecs[5] = '{"add_lsr",    2'd0, 2'd2, 3'd0, 3'd4, 3'd6, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h8004, 16'h4002, 3'b000};
      vecs[6] = '{"add_lsl",    2'd0, 2'd1, 3'd0, 3'd4, 3'd6, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h8004, 16'h0008, 3'b000};
      vecs[7] = '{"not_b",      2'd3, 2'd0, 3'd0, 3'd4, 3'd6, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h8004, 16'h7FFB, 3'b000};
      vecs[8] = '{"and_rd_rn",  2'd2, 2'd0, 3'd5, 3'd2, 3'd5, 1'b1, 16'h00FF, 1'b1, 16'h0F0F, 16'h0000, 16'h000F, 3'b000};
      vecs[9] = '{"add_same",   2'd0, 2'd0, 3'd2, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h1234, 16'h2468, 3'b000};

      reset = 1'b1; cmd_valid = 1'b0;
      set_cmd(2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0);
      repeat (2) @(negedge clk);
      check("rst cmd_ready", cmd_ready, 0);
      check("rst done", done, 0);
      check("rst rf_write", rf_write, 0);
      check("rst flags", {z_flag, n_flag, v_flag}, 0);
      check("rst readnum", rf_readnum, 0);
      check("rst writenum", rf_writenum, 0);
      check("rst wdata", rf_wdata, 0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         preload(vecs[i].rd, 16'hDEAD);
         preload(vecs[i].rn, vecs[i].a_val);
         if (!vecs[i].bsel) preload(vecs[i].rm, vecs[i].b_val);
         set_cmd(vecs[i].op, vecs[i].shift, vecs[i].rn, vecs[i].rm, vecs[i].rd,
                 vecs[i].bsel, vecs[i].imm, vecs[i].wb);
         run_cmd(vecs[i].name, vecs[i].wb);
         if (vecs[i].wb)                                exp_rd = vecs[i].exp_c;
         else if (vecs[i].rd == vecs[i].rn)             exp_rd = vecs[i].a_val;
         else if (!vecs[i].bsel && vecs[i].rd == vecs[i].rm) exp_rd = vecs[i].b_val;
         else                                           exp_rd = 16'hDEAD;
         check({vecs[i].name, " rd_value"}, rf[vecs[i].rd], exp_rd);
         check({vecs[i].name, " znv"}, {z_flag, n_flag, v_flag}, vecs[i].exp_znv);
      end

      // Flags hold while idle.
      repeat (3) @(negedge clk);
      check("flags_hold", {z_flag, n_flag, v_flag}, 3'b000);

      // cmd_valid held high: one accept every five cycles.
      preload(3'd5, 16'h0F0F);
      set_cmd(2'd2, 2'd0, 3'd5, 3'd0, 3'd5, 1'b1, 16'h00FF, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b1;
      accepts = 0; busy = 0; dones = 0; last_acc = -5;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) begin
            accepts++;
            check("hold gap", i - last_acc, 5);
            last_acc = i;
         end else busy++;
         if (done) dones++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("hold accepts", accepts, 4);
      check("hold busy", busy, 16);
      check("hold dones", dones, 4);
      check("hold r5", rf[5], 16'h000F);

      // Set N and V, then abort a command with reset during EXEC.
      preload(3'd1, 16'h7FFF);
      set_cmd(2'd0, 2'd0, 3'd1, 3'd0, 3'd3, 1'b1, 16'h0001, 1'b1);
      run_cmd("pre_abort", 1'b1);
      check("pre_abort znv", {z_flag, n_flag, v_flag}, 3'b011);
      preload(3'd3, 16'hABCD);
      set_cmd(2'd0, 2'd0, 3'd1, 3'd0, 3'd3, 1'b1, 16'h0001, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort cmd_ready", cmd_ready, 0);
      check("abort done", done, 0);
      check("abort rf_write", rf_write, 0);
      check("abort flags", {z_flag, n_flag, v_flag}, 3'b000);
      begin
         int wr_seen;
         wr_seen = 0;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rf_write || done) wr_seen++;
         end
         reset = 1'b0;
         #1;
         check("abort ready_release", cmd_ready, 1);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rf_write || done) wr_seen++;
         end
         check("abort no_write", wr_seen, 0);
      end
      check("abort r3", rf[3], 16'hABCD);

      // Normal command after release.
      preload(3'd2, 16'h0003);
      preload(3'd1, 16'h0005);
      set_cmd(2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b1);
      run_cmd("post_abort", 1'b1);
      check("post_abort r3", rf[3], 16'h0008);
      check("post_abort znv", {z_flag, n_flag, v_flag}, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execute stage that sits directly beside the 8x16 register file. It owns the register file's read port (readnum / data_out) and write port (writenum / write / data_in). For each accepted command it:
- reads two operands, one at a time,
- shifts operand B,
- performs one ALU operation,
- updates Z/N/V status flags,
- optionally writes the result back.

Parameters:
W, 16, datapath width; must equal register file data width
RW, 3, register index width (8 registers)

Ports:
clk  in  1  rising-edge clock, shared with register file
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted
op  in  2  00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B
shift  in  2  00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
rn  in  RW  register index for operand A
rm  in  RW  register index for operand B
rd  in  RW  destination register index
bsel  in  1  1: operand B taken from imm instead of rm
imm  in  W  immediate operand
wb_en  in  1  1: write result to rd; 0: flags only (compare)
rf_rdata  in  W  register file data_out (combinational read of rf_readnum)
rf_readnum  out  RW  register file readnum
rf_writenum  out  RW  register file writenum
rf_write  out  1  register file write enable
rf_wdata  out  W  register file data_in
done  out  1  one-cycle pulse, command complete
z_flag  out  1  result == 0
n_flag  out  1  result[W-1]
v_flag  out  1  signed overflow

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is asynchronous and active-high.
  - While reset is high: state=IDLE; A, B, C, the command field registers, rf_readnum, rf_writenum and all flags are 0; rf_write=0; done=0; cmd_ready=0.
- State register: IDLE -> LOAD_A -> LOAD_B -> EXEC -> WRITE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On a clock edge with cmd_valid=1: capture op, shift, rm, rd, bsel, imm, wb_en; set rf_readnum<=rn; go to LOAD_A.
- LOAD_A:
  - A<=rf_rdata (register rn).
  - rf_readnum<=rm.
  - Go to LOAD_B.
- LOAD_B:
  - B<=(bsel ? imm : rf_rdata).
  - Go to EXEC.
- EXEC:
  - Bs = shift(B). ASR1 replicates B[W-1].
  - C <= A+Bs, A-Bs, A&Bs, or ~Bs, according to op. Arithmetic is modulo 2^W.
  - Z, N and V are updated from the new C value at the same edge.
  - V: ADD sets V when the A and Bs signs are equal and differ from the result sign. SUB sets V when the A and Bs signs differ and the result sign differs from A. AND and NOT B clear V.
  - Go to WRITE.
- WRITE:
  - rf_write = wb_en.
  - rf_writenum = rd.
  - rf_wdata = C.
  - done=1.
  - The register file captures the result on the edge that leaves WRITE.
  - Go to IDLE.
- Output decode: rf_write, done and cmd_ready decode from the state register only. They do not depend combinationally on inputs. rf_writenum is held at the captured rd; rf_wdata = C at all times.
- Latency: accept edge T0; rf_write and done are high during the cycle after edge T3; the result is visible in the register file after edge T4. A new command can be accepted at edge T5 at the earliest. Throughput is 1 command per 5 cycles.
- Boundary conditions:
  - cmd_valid outside IDLE is ignored; no queueing.
  - rn==rm is legal; the same register is read twice.
  - rd==rn or rd==rm is legal; the write happens after both reads.
  - wb_en=0: no register file write; flags still update; done still pulses.
  - Flags hold their values between commands. Only EXEC and reset change them.
  - Reset asserted mid-command aborts immediately: no write is issued, and pending fields are discarded.
  - Reset released: the first accept is possible at the first rising edge where reset is low.

Test Plan:
- Preload R1=0x0005 and R2=0x0003 through the register file. Command ADD rn=1 rm=2 rd=3, shift none, wb_en=1 -> rf_write is high exactly 1 cycle, 4 cycles after accept; R3=0x0008; Z=0 N=0 V=0; done pulses once.
- R1=0x0005, R2=0x0005. Command SUB rd=3, wb_en=0 -> Z=1 N=0 V=0; rf_write never asserts; R3 unchanged; done pulses.
- R1=0x7FFF. Command ADD bsel=1 imm=0x0001 -> R3=0x8000, N=1, V=1, Z=0. Then SUB with R1=0x8000, imm=0x0001 -> 0x7FFF, V=1, N=0.
- R0=0x0000, R4=0x8004. Command ADD rn=0 rm=4 with shift ASR1 -> 0xC002; with LSR1 -> 0x4002; with LSL1 -> 0x0008. NOT B with no shift -> 0x7FFB.
- R5=0x0F0F. Command AND rn=5 bsel=1 imm=0x00FF rd=5 (rd==rn) -> R5=0x000F. Holding cmd_valid high throughout -> exactly one accept per 5 cycles, and cmd_ready is low for the 4 busy cycles.
- Assert reset asynchronously during EXEC -> state returns to IDLE within the same cycle; rf_write never goes high; flags and done read 0. The next command after release completes normally.
